// File: rtl/sync_pkg.sv
// Shared types and helpers for the multi-channel synchronizer/debouncer.
package sync_pkg;

   typedef enum logic [1:0] {S_LOW, S_PEND_H, S_HIGH, S_PEND_L} deb_state_t;

   function automatic int cnt_width(int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/sync_channel.sv
// One input channel: synchronizer chain, debounce FSM and cycle counter.
// Rise/fall pulse flops are built only when SYNC_EDGE_PULSE_EN is defined.
//
//  state    | meaning
//  S_LOW    | output low, input agrees
//  S_PEND_H | output low, counting consecutive high samples
//  S_HIGH   | output high, input agrees
//  S_PEND_L | output high, counting consecutive low samples
module sync_channel
   import sync_pkg::*;
#(
   parameter int STAGES          = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic value_i,
   output logic value_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [STAGES-1:0] sync;
   logic              s;
   deb_state_t        state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic              value_nxt;

   // Plain shift chain, nothing between the flops.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) sync <= '0;
      else         sync <= {sync[STAGES-2:0], value_i};
   end

   assign s = sync[STAGES-1];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_LOW: begin
            if (s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = S_HIGH;
               end else begin
                  state_nxt = S_PEND_H;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         S_PEND_H: begin
            if (!s) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = S_LOW;
               end else begin
                  state_nxt = S_PEND_L;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         S_PEND_L: begin
            if (s) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Output level follows the committed state, so pending states keep the old level.
   assign value_nxt = (state_nxt == S_HIGH) || (state_nxt == S_PEND_L);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state   <= S_LOW;
         cnt     <= '0;
         value_o <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         value_o <= value_nxt;
      end
   end

`ifdef SYNC_EDGE_PULSE_EN
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         rise_o <= value_nxt & ~value_o;
         fall_o <= ~value_nxt & value_o;
      end
   end
`else
   assign rise_o = 1'b0;
   assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/multi_sync_debounce.sv
// Multi-channel input conditioner: one sync_channel per input bit.
// Edge pulses exist only when SYNC_EDGE_PULSE_EN is defined.
module multi_sync_debounce
   import sync_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int STAGES          = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic [CHANNELS-1:0] value_i,
   output logic [CHANNELS-1:0] value_o,
   output logic [CHANNELS-1:0] rise_o,
   output logic [CHANNELS-1:0] fall_o
);

   if (CHANNELS < 1) begin : g_bad_channels
      $error("multi_sync_debounce: CHANNELS must be >= 1");
   end
   if (STAGES < 2) begin : g_bad_stages
      $error("multi_sync_debounce: STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("multi_sync_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      sync_channel #(
         .STAGES          (STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clock_i (clock_i),
         .reset_i (reset_i),
         .value_i (value_i[c]),
         .value_o (value_o[c]),
         .rise_o  (rise_o[c]),
         .fall_o  (fall_o[c])
      );
   end

endmodule
